// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one signed coefficient x sample multiplier among N_REQ requesters.
//   A round-robin arbiter accepts at most one request per cycle. The accepted
//   request enters a non-stalling multiply/shift pipeline. After exactly LAT
//   cycles the result returns with a one-hot tag that names its owner.
//
//   Build option: define MULT_SAT_EN to saturate the shifted product to the
//   D_W signed range. Without it, the low D_W bits are kept (two's-complement
//   wrap).
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_req_valid  [N_REQ]      request valid per requester
//   o_req_ready  [N_REQ]      one-hot grant (combinational), 0 while i_rst
//   i_req_coef   [N_REQ*C_W]  packed signed coefficients, req i at [i*C_W +: C_W]
//   i_req_data   [N_REQ*D_W]  packed signed samples, req i at [i*D_W +: D_W]
//   o_rsp_valid  [N_REQ]      one-hot, one-cycle result owner
//   o_rsp_data   [D_W]        signed result, 0 when o_rsp_valid == 0
//   o_busy                    any pipeline stage holds a valid entry
module mult_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int C_W   = 32,
   parameter int D_W   = 16,
   parameter int SHIFT = 30,
   parameter int LAT   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   input  logic [N_REQ*C_W-1:0]   i_req_coef,
   input  logic [N_REQ*D_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]       o_rsp_valid,
   output logic [D_W-1:0]         o_rsp_data,
   output logic                   o_busy
);

   localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int P_W = C_W + D_W;

   logic [PW-1:0]         r_ptr;
   logic [LAT:1]          r_vld_pipe;
   logic signed [C_W-1:0] r_coef;
   logic signed [D_W-1:0] r_data;
   logic [N_REQ-1:0]      r_tag;

   logic [N_REQ-1:0]      w_grant;
   logic [PW-1:0]         w_gidx;
   logic [PW:0]           w_idx;
   logic                  w_found;
   logic                  w_acc;
   logic signed [C_W-1:0] w_coef;
   logic signed [D_W-1:0] w_data;
   logic signed [P_W-1:0] w_prod;
   logic signed [P_W-1:0] w_shf;
   logic [D_W-1:0]        w_res;
   logic [D_W-1:0]        w_out_data;
   logic [N_REQ-1:0]      w_out_tag;

   // Round-robin search. Start at the pointer and wrap modulo N_REQ.
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_idx >= (PW+1)'(N_REQ))
            w_idx = w_idx - (PW+1)'(N_REQ);
         if (!w_found && i_req_valid[w_idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_gidx  = w_idx[PW-1:0];
         end
      end
      if (w_found && !i_rst)
         w_grant[w_gidx] = 1'b1;
   end

   assign w_acc       = w_found && !i_rst;
   assign o_req_ready = w_grant;

   // Operand mux, driven by the one-hot grant.
   always_comb begin
      w_coef = '0;
      w_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_coef = i_req_coef[i*C_W +: C_W];
            w_data = i_req_data[i*D_W +: D_W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_vld_pipe <= '0;
      end else begin
         r_vld_pipe[1] <= w_acc;
         for (int s = 2; s <= LAT; s++)
            r_vld_pipe[s] <= r_vld_pipe[s-1];
         if (w_acc)
            r_ptr <= (w_gidx == PW'(N_REQ-1)) ? '0 : w_gidx + 1'b1;
      end
   end

   // The datapath has no reset. The valid pipe masks stale contents.
   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         r_coef <= w_coef;
         r_data <= w_data;
         r_tag  <= w_grant;
      end
   end

   assign w_prod = $signed({{D_W{r_coef[C_W-1]}}, r_coef}) *
                   $signed({{C_W{r_data[D_W-1]}}, r_data});
   assign w_shf  = w_prod >>> SHIFT;   // floor toward -inf

`ifdef MULT_SAT_EN
   localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
   localparam logic signed [P_W-1:0] SAT_MIN = {{(P_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};
   always_comb begin
      if (w_shf > SAT_MAX)      w_res = SAT_MAX[D_W-1:0];
      else if (w_shf < SAT_MIN) w_res = SAT_MIN[D_W-1:0];
      else                      w_res = w_shf[D_W-1:0];
   end
`else
   logic [P_W-D_W-1:0] w_unused_hi;
   assign w_unused_hi = w_shf[P_W-1:D_W];
   assign w_res       = w_shf[D_W-1:0];
`endif

   // Pad to LAT. With LAT == 1, the result comes combinationally from stage 1.
   if (LAT == 1) begin : g_lat1
      assign w_out_data = w_res;
      assign w_out_tag  = r_tag;
   end else begin : g_latn
      logic [LAT:2][D_W-1:0]   r_res;
      logic [LAT:2][N_REQ-1:0] r_tagp;
      always_ff @(posedge i_clk) begin
         r_res[2]  <= w_res;
         r_tagp[2] <= r_tag;
         for (int s = 3; s <= LAT; s++) begin
            r_res[s]  <= r_res[s-1];
            r_tagp[s] <= r_tagp[s-1];
         end
      end
      assign w_out_data = r_res[LAT];
      assign w_out_tag  = r_tagp[LAT];
   end

   assign o_rsp_valid = r_vld_pipe[LAT] ? w_out_tag  : '0;
   assign o_rsp_data  = r_vld_pipe[LAT] ? w_out_data : '0;
   assign o_busy      = |r_vld_pipe;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter.
// The reference model keeps a queue of expected responses, each with its
// due cycle. Arbitration follows the round-robin pointer rule, and the
// arithmetic is floor division by 2^SHIFT followed by wrap or clamp.
module tb_mult_share_arbiter;
  localparam int N   = 4;
  localparam int CW  = 32;
  localparam int DW  = 16;
  localparam int SH  = 30;
  localparam int LAT = 2;
`ifdef MULT_SAT_EN
  localparam int OVF_EXP = 32767;
`else
  localparam int OVF_EXP = -5537;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld;
  logic [N*CW-1:0] coef;
  logic [N*DW-1:0] data;
  logic [N-1:0]    o_req_ready, o_rsp_valid;
  logic [DW-1:0]   o_rsp_data;
  logic            o_busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .C_W(CW), .D_W(DW), .SHIFT(SH), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .o_req_ready(o_req_ready),
    .i_req_coef(coef), .i_req_data(data), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .o_busy(o_busy));

  typedef struct { int due; int tag; int res; } ent_t;
  ent_t q[$];
  int   pass_cnt = 0, tot_cnt = 0;
  int   ptr = 0, cyc = 0, last_g = -1;
  bit   armed = 1'b0;
  int   s_ready, s_rv, s_data, s_busy;

  task automatic check(string name, longint act, longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
  endtask

  function automatic int ref_mult(longint c, longint d);
    longint p, div, r;
    p   = c * d;
    div = longint'(1) << SH;
    r   = p / div;
    if (p < 0 && r * div != p) r = r - 1;
`ifdef MULT_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`else
    r = r & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    return int'(r);
  endfunction

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++)
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Called at edge+1 with inputs already applied. The task samples mid-cycle,
  // compares against the model, then advances the model across the edge.
  task automatic cycle();
    int g, ev, ed;
    longint c, d;
    #3;
    g = model_grant();
    s_ready = int'(o_req_ready);
    s_rv    = int'(o_rsp_valid);
    s_data  = int'($signed(o_rsp_data));
    s_busy  = int'(o_busy);
    check("ready", s_ready, (g >= 0) ? (1 << g) : 0);
    if (armed) begin
      ev = 0; ed = 0;
      foreach (q[j]) if (q[j].due == cyc) begin ev = q[j].tag; ed = q[j].res; end
      check("rsp_valid", s_rv, ev);
      check("rsp_data", s_data, ed);
      check("busy", s_busy, (q.size() > 0) ? 1 : 0);
    end
    @(posedge clk);
    last_g = g;
    if (rst) begin
      q.delete();
      ptr   = 0;
      armed = 1'b1;
    end else if (g >= 0) begin
      c = longint'($signed(coef[g*CW +: CW]));
      d = longint'($signed(data[g*DW +: DW]));
      q.push_back('{cyc + LAT, 1 << g, ref_mult(c, d)});
      ptr = (g + 1) % N;
    end
    for (int j = q.size() - 1; j >= 0; j--) if (q[j].due <= cyc) q.delete(j);
    cyc++;
    #1;
  endtask

  task automatic set_req(int i, logic [CW-1:0] c, logic [DW-1:0] d);
    coef[i*CW +: CW] = c;
    data[i*DW +: DW] = d;
  endtask

  task automatic rand_req(int i);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    case ($urandom_range(0, 5))
      0:       c = 32'h0000_0000;
      1:       c = 32'h4000_0000;
      2:       c = 32'h2000_0000;
      3:       c = 32'h7FFF_FFFF;
      4:       c = 32'h8000_0000;
      default: c = $urandom;
    endcase
    d = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    set_req(i, c, d);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0;
    cycle();
    rst = 1'b0;
  endtask

  int exp_seq[6] = '{1, 2, 4, 8, 1, 2};
  int gr[8], rv[8];

  initial begin
    rst = 1'b1; vld = '0; coef = '0; data = '0;
    #1;
    cycle(); cycle();
    rst = 1'b0;

    // Pin the model with hand-computed values.
    check("pin_unity", ref_mult(longint'(1) << 30, 1000), 1000);
    check("pin_floor", ref_mult(longint'(1) << 29, -2001), -1001);
    check("pin_ovf", ref_mult(2147483647, 30000), OVF_EXP);
    check("pin_min", ref_mult(longint'(1) << 30, -32768), -32768);
    check("pin_zero", ref_mult(0, 12345), 0);

    // Reset state.
    cycle();
    check("rst_rv", s_rv, 0);
    check("rst_data", s_data, 0);
    check("rst_busy", s_busy, 0);

    // Unity gain on req0.
    set_req(0, 32'h4000_0000, 16'd1000); vld = 4'b0001;
    cycle();
    check("unity_ready", s_ready, 1);
    vld = '0;
    cycle();
    check("unity_busy1", s_busy, 1);
    cycle();
    check("unity_rv", s_rv, 1);
    check("unity_data", s_data, 1000);
    check("unity_busy2", s_busy, 1);
    cycle();
    check("unity_idle", s_busy, 0);

    // Half gain with a negative sample on req2.
    set_req(2, 32'h2000_0000, -16'sd2001); vld = 4'b0100;
    cycle();
    vld = '0;
    cycle(); cycle();
    check("half_rv", s_rv, 4);
    check("half_data", s_data, -1001);

    // Round robin from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000, 16'(i * 100 + 7));
    for (int i = 0; i < 8; i++) begin
      vld = (i < 6) ? 4'b1111 : 4'b0000;
      cycle();
      gr[i] = s_ready;
      rv[i] = s_rv;
    end
    for (int i = 0; i < 6; i++) begin
      check("rr_grant", gr[i], exp_seq[i]);
      check("rr_rsp", rv[i+2], exp_seq[i]);
    end

    // Overflow on req1. After the round robin the pointer is at 2.
    set_req(1, 32'h7FFF_FFFF, 16'd30000); vld = 4'b0010;
    cycle();
    vld = '0;
    cycle(); cycle();
    check("ovf_rv", s_rv, 2);
    check("ovf_data", s_data, OVF_EXP);

    // Reset while req3 is in flight.
    set_req(3, 32'h4000_0000, 16'd5); vld = 4'b1000;
    cycle();
    vld = '0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rstflt_rv", s_rv, 0);
    end
    // Pointer returns to 0 even if the last accept left it elsewhere.
    vld = 4'b0010;
    cycle();
    vld = '0; rst = 1'b1;
    cycle();
    rst = 1'b0; vld = 4'b1111;
    cycle();
    check("rst_ptr", s_ready, 1);
    vld = '0;
    cycle(); cycle(); cycle();

    // Withdraw: req1 drops valid before it is granted.
    do_reset();
    set_req(0, 32'h4000_0000, 16'd11); set_req(1, 32'h4000_0000, 16'd22);
    vld = 4'b0011;
    cycle();
    check("wd_grant0", s_ready, 1);
    vld = '0;
    cycle(); cycle();
    check("wd_rsp0", s_rv, 1);
    cycle();
    check("wd_none", s_rv, 0);
    vld = 4'b0011;
    cycle();
    check("wd_ptr", s_ready, 2);
    vld = '0;
    cycle(); cycle(); cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (vld[i] && last_g == i) begin
          vld[i] = 1'($urandom_range(0, 1));
          if (vld[i]) rand_req(i);
        end else if (vld[i]) begin
          if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1;
          rand_req(i);
        end
      end
      cycle();
    end
    rst = 1'b0; vld = '0;
    for (int i = 0; i < LAT + 2; i++) cycle();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
